// File: rtl/corelet_ctrl_pkg.sv
// corelet_ctrl_pkg: state encoding, instruction field positions and constants for corelet_ctrl
package corelet_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_W_FETCH, S_W_LOAD, S_W_FLUSH, S_A_FETCH, S_A_EXEC, S_DRAIN, S_DONE
  } state_e;
  localparam int B_MODE = 35;
  localparam int B_BYPASS = 34;
  localparam int B_ACC = 33;
  localparam int B_PCEN = 32;
  localparam int B_PWEN = 31;
  localparam int B_PA_LO = 20;
  localparam int B_XCEN = 19;
  localparam int B_XWEN = 18;
  localparam int B_XA_LO = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD = 3;
  localparam int B_L0_WR = 2;
  localparam int B_EXEC = 1;
  localparam int B_LOAD = 0;
  localparam logic [35:0] IDLE_INST = 36'h1800C0000;
  localparam int TIMEOUT_LIMIT = 1023;
endpackage

// File: rtl/corelet_inst_pack.sv
// corelet_inst_pack: packs the sequencer field signals into the 36-bit corelet instruction bundle
module corelet_inst_pack
  import corelet_ctrl_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              bypass_i,
  input  logic              acc_i,
  input  logic              pmem_wr_i,
  input  logic [ADDR_W-1:0] pa_i,
  input  logic              xmem_rd_i,
  input  logic [ADDR_W-1:0] xa_i,
  input  logic              ofifo_rd_i,
  input  logic              l0_rd_i,
  input  logic              l0_wr_i,
  input  logic              execute_i,
  input  logic              load_i,
  output logic [35:0]       inst_o
);
  always_comb begin
    inst_o = IDLE_INST;
    inst_o[B_MODE] = 1'b0;
    inst_o[B_BYPASS] = bypass_i;
    inst_o[B_ACC] = acc_i;
    inst_o[B_PCEN] = ~pmem_wr_i;
    inst_o[B_PWEN] = ~pmem_wr_i;
    inst_o[B_PA_LO +: ADDR_W] = pmem_wr_i ? pa_i : '0;
    inst_o[B_XCEN] = ~xmem_rd_i;
    inst_o[B_XWEN] = 1'b1;
    inst_o[B_XA_LO +: ADDR_W] = xmem_rd_i ? xa_i : '0;
    inst_o[B_OFIFO_RD] = ofifo_rd_i;
    inst_o[B_IFIFO_WR] = 1'b0;
    inst_o[B_IFIFO_RD] = 1'b0;
    inst_o[B_L0_RD] = l0_rd_i;
    inst_o[B_L0_WR] = l0_wr_i;
    inst_o[B_EXEC] = execute_i;
    inst_o[B_LOAD] = load_i;
  end
endmodule

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: weight-stationary tile-pass sequencer driving the corelet instruction bundle.
// Define CORELET_CTRL_TIMEOUT_EN to add the DRAIN watchdog and sticky err flag.
module corelet_ctrl
  import corelet_ctrl_pkg::*;
#(
  parameter int row = 8,
  parameter int col = 8,
  parameter int ADDR_W = 11,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] w_base_i,
  input  logic [ADDR_W-1:0] x_base_i,
  input  logic [ADDR_W-1:0] p_base_i,
  input  logic [CNT_W-1:0]  n_act_i,
  input  logic              acc_en_i,
  input  logic              ofifo_valid_i,
  output logic [35:0]       inst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int CW = (CNT_W + 1 > $clog2(row + col + 1)) ? CNT_W + 1 : $clog2(row + col + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, n_ext;
  logic [ADDR_W-1:0] w_base_q, x_base_q, p_base_q, pa_q, xa;
  logic [CNT_W-1:0] n_q;
  logic acc_q, l0_wr_q, pw_q, xmem_rd, ofifo_rd, timeout;
  assign n_ext = CW'(n_q);
  assign xmem_rd = state_q == S_W_FETCH || state_q == S_A_FETCH;
  assign xa = (state_q == S_W_FETCH ? w_base_q : x_base_q) + ADDR_W'(cnt_q);
  assign ofifo_rd = state_q == S_DRAIN && ofifo_valid_i && cnt_q != n_ext;
  assign busy_o = state_q != S_IDLE;
  assign done_o = state_q == S_DONE;
`ifdef CORELET_CTRL_TIMEOUT_EN
  logic [9:0] wd_q, wd_d;
  logic err_q;
  assign wd_d = (state_q == S_DRAIN && !ofifo_valid_i) ? wd_q + 10'd1 : '0;
  assign timeout = wd_d == 10'(TIMEOUT_LIMIT);
  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o = 1'b0;
`endif
  // LOAD/EXEC phases spend their first cycle on the trailing l0 write
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        state_d = start_i ? S_W_FETCH : S_IDLE;
      end
      S_W_FETCH: if (cnt_q == CW'(row - 1)) begin state_d = S_W_LOAD; cnt_d = '0; end
      S_W_LOAD: if (cnt_q == CW'(row)) begin state_d = S_W_FLUSH; cnt_d = '0; end
      S_W_FLUSH: if (cnt_q == CW'(row + col - 1)) begin
        state_d = n_q == '0 ? S_DONE : S_A_FETCH;
        cnt_d = '0;
      end
      S_A_FETCH: if (cnt_q == n_ext - CW'(1)) begin state_d = S_A_EXEC; cnt_d = '0; end
      S_A_EXEC: if (cnt_q == n_ext) begin state_d = S_DRAIN; cnt_d = '0; end
      S_DRAIN: begin
        cnt_d = cnt_q + CW'(ofifo_rd);
        if (cnt_q == n_ext) begin state_d = S_DONE; cnt_d = '0; end
      end
      default: begin state_d = S_IDLE; cnt_d = '0; end
    endcase
    if (timeout || abort_i) begin state_d = S_IDLE; cnt_d = '0; end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      l0_wr_q <= 1'b0;
      pw_q <= 1'b0;
      pa_q <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
      n_q <= '0;
      acc_q <= 1'b0;
`ifdef CORELET_CTRL_TIMEOUT_EN
      wd_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      l0_wr_q <= xmem_rd & ~abort_i;
      pw_q <= ofifo_rd & ~abort_i;
      pa_q <= p_base_q + ADDR_W'(cnt_q);
      if (state_q == S_IDLE && start_i) begin
        w_base_q <= w_base_i;
        x_base_q <= x_base_i;
        p_base_q <= p_base_i;
        n_q <= n_act_i;
        acc_q <= acc_en_i;
      end
`ifdef CORELET_CTRL_TIMEOUT_EN
      wd_q <= wd_d;
      err_q <= err_q | (timeout & ~abort_i);
`endif
    end
  end
  corelet_inst_pack #(.ADDR_W(ADDR_W)) u_pack (
    .bypass_i  (state_q == S_DRAIN),
    .acc_i     (state_q == S_DRAIN && acc_q),
    .pmem_wr_i (pw_q),
    .pa_i      (pa_q),
    .xmem_rd_i (xmem_rd),
    .xa_i      (xa),
    .ofifo_rd_i(ofifo_rd),
    .l0_rd_i   ((state_q == S_W_LOAD || state_q == S_A_EXEC) && cnt_q != '0),
    .l0_wr_i   (l0_wr_q),
    .execute_i (state_q == S_A_EXEC && cnt_q != '0),
    .load_i    (state_q == S_W_LOAD && cnt_q != '0),
    .inst_o    (inst_o)
  );
endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: directed tile passes checked every cycle against a cycle-offset model of the pass
module tb_corelet_ctrl;
  localparam int R = 8;
  localparam int C = 8;
  localparam int TLIM = 1023;
  localparam logic [35:0] IDLE = 36'h1800C0000;
`ifdef CORELET_CTRL_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, acc_en = 1'b0, ofifo_valid = 1'b0;
  logic [10:0] w_base = '0, x_base = '0, p_base = '0;
  logic [7:0] n_act = '0;
  logic [35:0] inst_o;
  logic busy_o, done_o, err_o;
  int n_chk = 0, n_fail = 0;
  bit m_act = 0, m_done = 0, m_pend = 0, m_acc = 0, m_err = 0;
  int m_o = 0, m_reads = 0, m_zr = 0, m_w = 0, m_x = 0, m_p = 0, m_n = 0, m_pa = 0;
  int xq[$], pq[$];
  int n_load = 0, n_exec = 0, n_ofrd = 0, n_done = 0;
  corelet_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .w_base_i(w_base), .x_base_i(x_base), .p_base_i(p_base), .n_act_i(n_act),
    .acc_en_i(acc_en), .ofifo_valid_i(ofifo_valid),
    .inst_o(inst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask
  task automatic chk_q(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++) chk(nm, 64'(got[i]), 64'(exp[i]));
  endtask
  function automatic logic [35:0] pack(bit byp, bit acc, bit pw, int pa, bit xrd, int xa,
                                       bit ofrd, bit l0rd, bit l0wr, bit ex, bit ld);
    logic [10:0] pa11, xa11;
    pa11 = pw ? 11'(pa) : 11'd0;
    xa11 = xrd ? 11'(xa) : 11'd0;
    return {1'b0, byp, acc, ~pw, ~pw, pa11, ~xrd, 1'b1, xa11, ofrd, 2'b00, l0rd, l0wr, ex, ld};
  endfunction
  function automatic bit in_drain();
    return m_act && !m_done && m_n > 0 && m_o >= 3*R + C + 3 + 2*m_n;
  endfunction
  // Expected bundle from the pass offset: fetch, load, flush, fetch, exec windows, then drain
  function automatic logic [35:0] model_inst();
    int o, a0, xa;
    bit xrd, l0wr, l0rd, ld, ex, dr;
    if (!m_act || m_done) return IDLE;
    o = m_o; a0 = 3*R + C + 2; xa = 0;
    xrd = 0; l0wr = 0; l0rd = 0; ld = 0; ex = 0;
    if (o <= R) begin xrd = 1; xa = m_w + o - 1; end
    if (o >= 2 && o <= R + 1) l0wr = 1;
    if (o >= R + 2 && o <= 2*R + 1) begin l0rd = 1; ld = 1; end
    if (m_n > 0) begin
      if (o >= a0 && o < a0 + m_n) begin xrd = 1; xa = m_x + o - a0; end
      if (o > a0 && o <= a0 + m_n) l0wr = 1;
      if (o > a0 + m_n && o <= a0 + 2*m_n) begin l0rd = 1; ex = 1; end
    end
    dr = in_drain();
    return pack(dr, dr && m_acc, dr && m_pend, m_pa, xrd, xa,
                dr && ofifo_valid && m_reads < m_n, l0rd, l0wr, ex, ld);
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 0; m_done <= 0; m_pend <= 0; m_err <= 0; m_o <= 0; m_reads <= 0; m_zr <= 0;
    end else if (abort) begin
      m_act <= 0; m_done <= 0;
    end else if (!m_act) begin
      if (start) begin
        m_act <= 1; m_o <= 1; m_reads <= 0; m_pend <= 0; m_zr <= 0;
        m_w <= int'(w_base); m_x <= int'(x_base); m_p <= int'(p_base); m_n <= int'(n_act);
        m_acc <= acc_en;
      end
    end else if (m_done) begin
      m_act <= 0; m_done <= 0;
    end else if (in_drain()) begin
      m_zr <= ofifo_valid ? 0 : m_zr + 1;
      m_o <= m_o + 1;
      if (TO && !ofifo_valid && m_zr == TLIM - 1) begin
        m_err <= 1; m_act <= 0;
      end else if (m_reads == m_n) m_done <= 1;
      else begin
        m_pend <= ofifo_valid;
        m_pa <= (m_p + m_reads) % 2048;
        m_reads <= m_reads + (ofifo_valid ? 1 : 0);
      end
    end else begin
      if (m_n == 0 && m_o == 3*R + C + 1) m_done <= 1;
      m_o <= m_o + 1;
    end
  end
  always @(negedge clk) begin
    chk("inst", 64'(inst_o), 64'(model_inst()));
    chk("busy", 64'(busy_o), 64'(m_act));
    chk("done", 64'(done_o), 64'(m_act && m_done));
    chk("err", 64'(err_o), 64'(m_err));
  end
  always @(negedge clk) if (rst_n) begin
    if (!inst_o[19]) xq.push_back(int'(inst_o[17:7]));
    if (!inst_o[32] && !inst_o[31]) pq.push_back(int'(inst_o[30:20]));
    n_load += int'(inst_o[0]);
    n_exec += int'(inst_o[1]);
    n_ofrd += int'(inst_o[6]);
    n_done += int'(done_o);
  end
  task automatic clear_logs();
    xq.delete(); pq.delete();
    n_load = 0; n_exec = 0; n_ofrd = 0; n_done = 0;
  endtask
  function automatic logic vpat(int mode, int lat, int d);
    if (mode == 0) return 1'b1;
    if (mode == 1) return lat >= d && (lat - d) % 3 == 0;
    return 1'b0;
  endfunction
  task automatic launch(input int w, input int x, input int p, input int n, input bit acc);
    clear_logs();
    w_base = 11'(w); x_base = 11'(x); p_base = 11'(p); n_act = 8'(n); acc_en = acc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic run_pass(input int w, input int x, input int p, input int n, input bit acc,
                          input int vmode, output int lat);
    int d;
    d = 3*R + C + 3 + 2*n;
    ofifo_valid = vpat(vmode, 0, d);
    launch(w, x, p, n, acc);
    lat = 1;
    ofifo_valid = vpat(vmode, lat, d);
    while (!done_o && !err_o && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
      ofifo_valid = vpat(vmode, lat, d);
    end
    chk("pass_within_bound", 64'(lat < 3000), 64'(1));
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat;
    int e[$];
    repeat (3) @(posedge clk);
    #1;
    chk("reset_inst", 64'(inst_o), 64'(36'h1800C0000));
    chk("reset_busy", 64'(busy_o), 64'(0));
    chk("reset_done", 64'(done_o), 64'(0));
    chk("reset_err", 64'(err_o), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_pass(0, 16, 32, 4, 1'b1, 0, lat);
    chk("basic_latency", 64'(lat), 64'(48));
    e = '{0, 1, 2, 3, 4, 5, 6, 7, 16, 17, 18, 19};
    chk_q("basic_xaddr", xq, e);
    e = '{32, 33, 34, 35};
    chk_q("basic_paddr", pq, e);
    chk("basic_loads", 64'(n_load), 64'(8));
    chk("basic_execs", 64'(n_exec), 64'(4));
    chk("basic_done_pulses", 64'(n_done), 64'(1));
    run_pass(40, 50, 60, 0, 1'b0, 0, lat);
    chk("zero_latency", 64'(lat), 64'(34));
    chk("zero_loads", 64'(n_load), 64'(8));
    chk("zero_execs", 64'(n_exec), 64'(0));
    chk("zero_writes", 64'(pq.size()), 64'(0));
    chk("zero_xreads", 64'(xq.size()), 64'(8));
    chk("zero_done_pulses", 64'(n_done), 64'(1));
    run_pass(1, 2, 100, 3, 1'b0, 1, lat);
    chk("stall_latency", 64'(lat), 64'(49));
    e = '{100, 101, 102};
    chk_q("stall_paddr", pq, e);
    chk("stall_ofifo_reads", 64'(n_ofrd), 64'(3));
    run_pass(2044, 2046, 2046, 4, 1'b1, 0, lat);
    chk("wrap_latency", 64'(lat), 64'(48));
    e = '{2044, 2045, 2046, 2047, 0, 1, 2, 3, 2046, 2047, 0, 1};
    chk_q("wrap_xaddr", xq, e);
    e = '{2046, 2047, 0, 1};
    chk_q("wrap_paddr", pq, e);
    launch(5, 9, 3, 5, 1'b0);
    for (int i = 1; i < 41; i++) begin
      @(posedge clk); #1;
      start = (i == 20);
    end
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 64'(busy_o), 64'(0));
    chk("abort_inst", 64'(inst_o), 64'(36'h1800C0000));
    repeat (4) @(posedge clk);
    #1;
    chk("abort_execs", 64'(n_exec), 64'(2));
    chk("abort_no_done", 64'(n_done), 64'(0));
    chk("abort_stays_idle", 64'(busy_o), 64'(0));
`ifdef CORELET_CTRL_TIMEOUT_EN
    run_pass(0, 0, 0, 2, 1'b0, 2, lat);
    chk("timeout_latency", 64'(lat), 64'(1062));
    chk("timeout_err", 64'(err_o), 64'(1));
    chk("timeout_busy", 64'(busy_o), 64'(0));
    chk("timeout_no_done", 64'(n_done), 64'(0));
    chk("timeout_no_reads", 64'(n_ofrd), 64'(0));
`endif
    launch(0, 16, 32, 4, 1'b1);
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_inst", 64'(inst_o), 64'(36'h1800C0000));
    chk("midreset_busy", 64'(busy_o), 64'(0));
    chk("midreset_done", 64'(done_o), 64'(0));
    chk("midreset_err", 64'(err_o), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_stays_idle", 64'(busy_o), 64'(0));
    chk("midreset_no_done", 64'(n_done), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/corelet_ctrl.md
# corelet_ctrl

Sequencer that drives the 36-bit instruction bundle of the corelet for one weight-stationary tile pass: fetch weights from xmem into L0, shift them into the MAC array, fetch and stream activation vectors, then drain the OFIFO through the SFU and write results to pmem. It sits between the testbench/top-level command source and the core, and replaces hand-written per-cycle instruction vectors with a single start/done handshake.

## Interface
- row, 8, MAC array rows (L0 width in vectors)
- col, 8, MAC array columns
- ADDR_W, 11, xmem/pmem address width
- CNT_W, 8, activation-vector count width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- abort  in  1  synchronous abort; return to IDLE next cycle
- w_base  in  ADDR_W  xmem address of first weight vector
- x_base  in  ADDR_W  xmem address of first activation vector
- p_base  in  ADDR_W  pmem address of first output vector
- n_act  in  CNT_W  number of activation vectors (0 allowed)
- acc_en  in  1  SFU accumulate (1) vs ReLU-and-clear (0) during drain
- ofifo_valid  in  1  corelet OFIFO has a vector
- inst  out  36  corelet instruction bundle
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse on pass completion
- err  out  1  sticky drain-timeout flag (see Configuration)

## Operation
- inst fields: [35] mode (tied 0, WS); [34] bypass/pmem_rd; [33] acc; [32] pmem CEN_n; [31] pmem WEN_n; [30:20] pmem A; [19] xmem CEN_n; [18] xmem WEN_n; [17:7] xmem A; [6] ofifo_rd; [5] ififo_wr=0; [4] ififo_rd=0; [3] l0_rd; [2] l0_wr; [1] execute; [0] load.
- Idle bundle IDLE_INST = 36'h1800C0000 (all CEN_n/WEN_n high, everything else 0).
- States: IDLE -> W_FETCH -> W_LOAD -> W_FLUSH -> A_FETCH -> A_EXEC -> DRAIN -> DONE -> IDLE.
- IDLE: start latches bases, n_act, acc_en; go W_FETCH.
- W_FETCH: row cycles, xmem read (CEN_n=0, WEN_n=1) at w_base+i, i=0..row-1.
- W_LOAD: row cycles, l0_rd=1, load=1.
- W_FLUSH: row+col idle cycles for weights to settle; if n_act==0 go DONE.
- A_FETCH: n_act cycles, xmem read at x_base+j.
- A_EXEC: n_act cycles, l0_rd=1, execute=1.
- DRAIN: bypass=1, acc=acc_en; ofifo_rd=ofifo_valid; count reads; after n_act reads (last write issued) go DONE.
- DONE: done=1 one cycle, inst=IDLE_INST; go IDLE.
- Address arithmetic modulo 2^ADDR_W (wraps, no error).
- start while busy ignored; abort has priority over every transition, flushes pipeline registers, no done pulse.

## Timing
- Reset: inst=IDLE_INST, busy=0, done=0, err=0, state IDLE, counters 0.
- start in cycle t -> first xmem read in t+1; busy high from t+1.
- xmem read latency 1: l0_wr asserted the cycle after each xmem read (delayed-register), so last l0_wr in the first cycle of the next state; W_LOAD/A_EXEC begin after that trailing write.
- SFU output registered: pmem write (CEN_n=0, WEN_n=0, A=p_base+k) one cycle after each ofifo_rd; DONE entered after the last write cycle.
- ofifo_rd never asserted when ofifo_valid=0; gaps in ofifo_valid stall drain, not skip.
- done and return to IDLE: start accepted again the cycle after done.

## Configuration
- CORELET_CTRL_TIMEOUT_EN defined: 10-bit watchdog counts consecutive DRAIN cycles with ofifo_valid=0; reaching 1023 sets err (sticky until reset), inst=IDLE_INST, go IDLE without done.
- Undefined: no watchdog, DRAIN waits indefinitely, err tied 0.

## Structure
- Package corelet_ctrl_pkg: state enum, inst field bit positions, IDLE_INST constant, timeout limit.
- One sub-module corelet_inst_pack: combinational packing of field signals into the 36-bit bundle; FSM, counters, and delay registers stay in corelet_ctrl.

## Test plan
- Reset mid-W_LOAD (reset low 2 cycles) -> inst=36'h1800C0000, busy=0 immediately, no done.
- start, w_base=0, x_base=16, p_base=32, n_act=4, ofifo_valid=1 constant -> xmem reads 0..7 then 16..19, 8 load cycles, 4 execute cycles, pmem writes 32..35, one done pulse.
- n_act=0 -> weights fetched/loaded, no execute, no pmem write, done after W_FLUSH.
- ofifo_valid toggled 1,0,0,1,... in DRAIN with n_act=3 -> ofifo_rd only on valid cycles, exactly 3 writes at p_base..p_base+2.
- x_base=2046, n_act=4 -> xmem addresses 2046,2047,0,1.
- CORELET_CTRL_TIMEOUT_EN, ofifo_valid stuck 0 -> err=1 after 1023 cycles, busy=0, no done; start pulsed mid-pass and abort mid-A_EXEC -> start ignored, IDLE next cycle.
